lru_tracker: RTL and testbench

Parametrised replacement-state tracker for the set-associative caches. It generalises the two-way LRU bit array to SETS sets of WAYS ways, using per-set tree pseudo-LRU bits plus per-way valid bits. It sits beside the tag array: the cache controller reports hits and fills (touch) and invalidations, and queries the victim way for a set before a fill. A sequential flush engine clears all state without a reset.

---
 rtl/lru_tracker.sv | 149 ++++++++++++++
 tb/tb_lru_tracker.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/lru_tracker.sv
// rtl/lru_tracker.sv - per-set tree pseudo-LRU plus valid bits with victim query and flush engine
// Optional LRU_BYPASS_EN forwards same-cycle, same-set touch/inval into the victim query.
module lru_tracker #(
  parameter int SETS = 64,
  parameter int WAYS = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     touch_en,
  input  logic [$clog2(SETS)-1:0]  touch_set,
  input  logic [$clog2(WAYS)-1:0]  touch_way,
  input  logic                     inval_en,
  input  logic [$clog2(SETS)-1:0]  inval_set,
  input  logic [$clog2(WAYS)-1:0]  inval_way,
  input  logic                     vq_en,
  input  logic [$clog2(SETS)-1:0]  vq_set,
  output logic                     vq_valid,
  output logic [$clog2(WAYS)-1:0]  vq_way,
  output logic                     vq_free,
  input  logic                     flush,
  output logic                     busy
);

  localparam int SET_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t             state_q, state_nx;
  logic [SET_W-1:0]   cnt_q, cnt_nx;

  // Tree node n (heap order, root = 1) lives at bit n.
  logic [WAYS-1:1]    tree_q  [SETS];
  logic [WAYS-1:0]    valid_q [SETS];

  logic [WAYS-1:1]    vq_tree;
  logic [WAYS-1:0]    vq_vld;

  // Point every ancestor of w away from it.
  function automatic logic [WAYS-1:1] tree_touch(input logic [WAYS-1:1] t,
                                                 input logic [WAY_W-1:0] w);
    logic [WAY_W-1:0] node;
    tree_touch = t;
    for (int l = 0; l < WAY_W; l++) begin
      node = WAY_W'(1 << l) | WAY_W'(w >> (WAY_W - l));
      tree_touch[node] = ~w[WAY_W-1-l];
    end
  endfunction

  function automatic logic [WAY_W-1:0] tree_walk(input logic [WAYS-1:1] t);
    logic [WAY_W:0] node;
    node = (WAY_W+1)'(1);
    for (int l = 0; l < WAY_W; l++)
      node = {node[WAY_W-1:0], t[node[WAY_W-1:0]]};
    return node[WAY_W-1:0];
  endfunction

  function automatic logic [WAY_W-1:0] lowest_invalid(input logic [WAYS-1:0] v);
    logic [WAY_W-1:0] w;
    w = '0;
    for (int i = WAYS - 1; i >= 0; i--)
      if (!v[i]) w = WAY_W'(i);
    return w;
  endfunction

  assign busy = (state_q == FLUSH);

  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    case (state_q)
      IDLE: begin
        if (flush) begin
          state_nx = FLUSH;
          cnt_nx   = '0;
        end
      end
      FLUSH: begin
        cnt_nx = cnt_q + SET_W'(1);
        if (cnt_q == SET_W'(SETS - 1)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
    end
  end

  // Inval is written after touch so it wins the valid bit on a same-way collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SETS; i++) begin
        tree_q[i]  <= '0;
        valid_q[i] <= '0;
      end
    end else if (busy) begin
      tree_q[cnt_q]  <= '0;
      valid_q[cnt_q] <= '0;
    end else begin
      if (touch_en) begin
        tree_q[touch_set]             <= tree_touch(tree_q[touch_set], touch_way);
        valid_q[touch_set][touch_way] <= 1'b1;
      end
      if (inval_en)
        valid_q[inval_set][inval_way] <= 1'b0;
    end
  end

  always_comb begin
    vq_tree = tree_q[vq_set];
    vq_vld  = valid_q[vq_set];
`ifdef LRU_BYPASS_EN
    if (touch_en && (touch_set == vq_set)) begin
      vq_tree            = tree_touch(vq_tree, touch_way);
      vq_vld[touch_way]  = 1'b1;
    end
    if (inval_en && (inval_set == vq_set))
      vq_vld[inval_way] = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vq_valid <= 1'b0;
      vq_way   <= '0;
      vq_free  <= 1'b0;
    end else begin
      vq_valid <= vq_en && !busy;
      if (vq_en && !busy) begin
        vq_free <= ~&vq_vld;
        vq_way  <= (~&vq_vld) ? lowest_invalid(vq_vld) : tree_walk(vq_tree);
      end
    end
  end

endmodule

// File: tb/tb_lru_tracker.sv
// tb/tb_lru_tracker.sv - directed self-checking bench for lru_tracker (SETS=64, WAYS=4)
module tb_lru_tracker;

  localparam int SETS = 64;
  localparam int WAYS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       touch_en = 1'b0;
  logic [5:0] touch_set = '0;
  logic [1:0] touch_way = '0;
  logic       inval_en = 1'b0;
  logic [5:0] inval_set = '0;
  logic [1:0] inval_way = '0;
  logic       vq_en = 1'b0;
  logic [5:0] vq_set = '0;
  logic       vq_valid;
  logic [1:0] vq_way;
  logic       vq_free;
  logic       flush = 1'b0;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lru_tracker #(.SETS(SETS), .WAYS(WAYS)) dut (
    .clk(clk), .rst(rst),
    .touch_en(touch_en), .touch_set(touch_set), .touch_way(touch_way),
    .inval_en(inval_en), .inval_set(inval_set), .inval_way(inval_way),
    .vq_en(vq_en), .vq_set(vq_set),
    .vq_valid(vq_valid), .vq_way(vq_way), .vq_free(vq_free),
    .flush(flush), .busy(busy)
  );

  // Drive helpers: called at a negedge, return at the following negedge.
  task automatic do_touch(input logic [5:0] s, input logic [1:0] w);
    touch_en = 1'b1; touch_set = s; touch_way = w;
    @(negedge clk);
    touch_en = 1'b0;
  endtask

  task automatic do_inval(input logic [5:0] s, input logic [1:0] w);
    inval_en = 1'b1; inval_set = s; inval_way = w;
    @(negedge clk);
    inval_en = 1'b0;
  endtask

  task automatic do_query(input logic [5:0] s);
    vq_en = 1'b1; vq_set = s;
    @(negedge clk);
    vq_en = 1'b0;
  endtask

  task automatic fill_set(input logic [5:0] s);
    for (int w = 0; w < WAYS; w++) do_touch(s, 2'(w));
  endtask

  task automatic test_reset();
    #2;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if ({vq_valid, vq_way, vq_free} !== 4'b0) begin n_err++;
      $display("FAIL reset_outputs got valid=%b way=%0d free=%b want 0/0/0", vq_valid, vq_way, vq_free); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_query(6'd0);
    n_vec++; if ({vq_valid, vq_way, vq_free} !== {1'b1, 2'd0, 1'b1}) begin n_err++;
      $display("FAIL reset_query got valid=%b way=%0d free=%b want 1/0/1", vq_valid, vq_way, vq_free); end
    @(negedge clk);
    n_vec++; if ({vq_valid, vq_way, vq_free} !== {1'b0, 2'd0, 1'b1}) begin n_err++;
      $display("FAIL query_hold got valid=%b way=%0d free=%b want 0/0/1", vq_valid, vq_way, vq_free); end
  endtask

  task automatic test_plru();
    fill_set(6'd5);
    do_query(6'd5);
    n_vec++; if ({vq_valid, vq_way, vq_free} !== {1'b1, 2'd0, 1'b0}) begin n_err++;
      $display("FAIL plru_full got valid=%b way=%0d free=%b want 1/0/0", vq_valid, vq_way, vq_free); end
    do_touch(6'd5, 2'd0);
    do_query(6'd5);
    n_vec++; if ({vq_valid, vq_way, vq_free} !== {1'b1, 2'd2, 1'b0}) begin n_err++;
      $display("FAIL plru_touch0 got valid=%b way=%0d free=%b want 1/2/0", vq_valid, vq_way, vq_free); end
    do_touch(6'd5, 2'd2);
    do_query(6'd5);
    n_vec++; if ({vq_way, vq_free} !== {2'd1, 1'b0}) begin n_err++;
      $display("FAIL plru_touch2 got way=%0d free=%b want 1/0", vq_way, vq_free); end
  endtask

  task automatic test_invalidate();
    fill_set(6'd7);
    do_inval(6'd7, 2'd2);
    do_query(6'd7);
    n_vec++; if ({vq_valid, vq_way, vq_free} !== {1'b1, 2'd2, 1'b1}) begin n_err++;
      $display("FAIL inval_free got valid=%b way=%0d free=%b want 1/2/1", vq_valid, vq_way, vq_free); end
    do_touch(6'd7, 2'd2);
    do_query(6'd7);
    n_vec++; if ({vq_way, vq_free} !== {2'd0, 1'b0}) begin n_err++;
      $display("FAIL inval_refill got way=%0d free=%b want 0/0", vq_way, vq_free); end
  endtask

  task automatic test_same_cycle();
    fill_set(6'd3);
    touch_en = 1'b1; touch_set = 6'd3; touch_way = 2'd1;
    inval_en = 1'b1; inval_set = 6'd3; inval_way = 2'd1;
    do_query(6'd3);
    touch_en = 1'b0; inval_en = 1'b0;
`ifdef LRU_BYPASS_EN
    n_vec++; if ({vq_valid, vq_way, vq_free} !== {1'b1, 2'd1, 1'b1}) begin n_err++;
      $display("FAIL collide_bypass got valid=%b way=%0d free=%b want 1/1/1", vq_valid, vq_way, vq_free); end
`else
    n_vec++; if ({vq_valid, vq_way, vq_free} !== {1'b1, 2'd0, 1'b0}) begin n_err++;
      $display("FAIL collide_pre got valid=%b way=%0d free=%b want 1/0/0", vq_valid, vq_way, vq_free); end
`endif
    do_query(6'd3);
    n_vec++; if ({vq_way, vq_free} !== {2'd1, 1'b1}) begin n_err++;
      $display("FAIL collide_after got way=%0d free=%b want 1/1", vq_way, vq_free); end
    // Different ways, same set: both land; way 0 invalid beats tree.
    touch_en = 1'b1; touch_set = 6'd3; touch_way = 2'd1;
    inval_en = 1'b1; inval_set = 6'd3; inval_way = 2'd0;
    @(negedge clk);
    touch_en = 1'b0; inval_en = 1'b0;
    do_query(6'd3);
    n_vec++; if ({vq_way, vq_free} !== {2'd0, 1'b1}) begin n_err++;
      $display("FAIL collide_diff got way=%0d free=%b want 0/1", vq_way, vq_free); end
  endtask

  task automatic test_flush();
    int cycles;
    fill_set(6'd63);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      if (cycles == 5) begin vq_en = 1'b1; vq_set = 6'd63; end
      if (cycles == 20) flush = 1'b1;
      @(negedge clk);
      if (cycles == 5) begin
        vq_en = 1'b0;
        n_vec++; if (vq_valid !== 1'b0) begin n_err++; $display("FAIL busy_query got vq_valid=%b want 0", vq_valid); end
      end
      flush = 1'b0;
    end
    n_vec++; if (cycles !== SETS) begin n_err++; $display("FAIL busy_len got %0d cycles want %0d", cycles, SETS); end
    do_query(6'd63);
    n_vec++; if ({vq_valid, vq_way, vq_free} !== {1'b1, 2'd0, 1'b1}) begin n_err++;
      $display("FAIL flush_cleared got valid=%b way=%0d free=%b want 1/0/1", vq_valid, vq_way, vq_free); end
    do_query(6'd5);
    n_vec++; if ({vq_way, vq_free} !== {2'd0, 1'b1}) begin n_err++;
      $display("FAIL flush_set5 got way=%0d free=%b want 0/1", vq_way, vq_free); end
  endtask

  task automatic test_reset_mid_flush();
    do_touch(6'd40, 2'd0);
    do_query(6'd40);
    n_vec++; if ({vq_way, vq_free} !== {2'd1, 1'b1}) begin n_err++;
      $display("FAIL pre_abort got way=%0d free=%b want 1/1", vq_way, vq_free); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", busy); end
    n_vec++; if ({vq_valid, vq_way, vq_free} !== 4'b0) begin n_err++;
      $display("FAIL abort_outputs got valid=%b way=%0d free=%b want 0/0/0", vq_valid, vq_way, vq_free); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_idle got busy=%b want 0", busy); end
    do_query(6'd40);
    n_vec++; if ({vq_valid, vq_way, vq_free} !== {1'b1, 2'd0, 1'b1}) begin n_err++;
      $display("FAIL abort_cleared got valid=%b way=%0d free=%b want 1/0/1", vq_valid, vq_way, vq_free); end
  endtask

  initial begin
    test_reset();
    test_plru();
    test_invalidate();
    test_same_cycle();
    test_flush();
    test_reset_mid_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1);
  end

endmodule
